// File: rtl/sd_wrr_sched_if.sv
// sd_wrr_sched_if: requester channels, weights and the shared output channel of sd_wrr_sched.
interface sd_wrr_sched_if #(
  parameter int inputs   = 4,
  parameter int width    = 8,
  parameter int wt_width = 4
);
  logic [inputs-1:0]          c_srdy;
  logic [inputs-1:0]          c_drdy;
  logic [inputs*width-1:0]    c_data;
  logic [inputs-1:0]          c_eop;
  logic [inputs*wt_width-1:0] cfg_weight;
  logic                       p_srdy;
  logic                       p_drdy;
  logic [width-1:0]           p_data;
  logic [inputs-1:0]          p_grant;
  modport master (
    output c_srdy, c_data, c_eop, cfg_weight, p_drdy,
    input  c_drdy, p_srdy, p_data, p_grant
  );
  modport slave (
    input  c_srdy, c_data, c_eop, cfg_weight, p_drdy,
    output c_drdy, p_srdy, p_data, p_grant
  );
endinterface

// File: rtl/sd_wrr_sched.sv
// sd_wrr_sched: weighted round-robin scheduler onto one registered srdy/drdy channel.
// Define SD_WRR_SCHED_EOP_LOCK_EN to lock grants to whole packets (credit counts packets).
module sd_wrr_sched #(
  parameter int inputs   = 4,
  parameter int width    = 8,
  parameter int wt_width = 4
) (
  input logic           clk,
  input logic           reset,
  sd_wrr_sched_if.slave bus
);
  localparam int iw = $clog2(inputs);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t               state_q, state_d;
  logic [iw-1:0]        rr_q, rr_d, gnt_q, gnt_d, pick, gnt_nx;
  logic [wt_width-1:0]  credit_q, credit_d, wt;
  logic                 p_srdy_q, p_srdy_d;
  logic [width-1:0]     p_data_q, p_data_d;
  logic [inputs-1:0]    p_grant_q, p_grant_d, gnt_oh;
  logic                 hit, ok, xfer, dec, rel;
  // Walk downward so the requester closest to rr_q wins.
  always_comb begin
    hit = 1'b0;
    pick = '0;
    for (int i = inputs - 1; i >= 0; i--)
      if (bus.c_srdy[(int'(rr_q) + i) % inputs]) begin
        hit = 1'b1;
        pick = iw'((int'(rr_q) + i) % inputs);
      end
  end
  assign wt = bus.cfg_weight[pick*wt_width +: wt_width];
  assign gnt_oh = inputs'(1) << gnt_q;
  assign gnt_nx = gnt_q == iw'(inputs - 1) ? '0 : gnt_q + 1'b1;
  assign ok = state_q == GRANT && (!p_srdy_q || bus.p_drdy);
  assign xfer = ok && bus.c_srdy[gnt_q];
`ifdef SD_WRR_SCHED_EOP_LOCK_EN
  assign dec = xfer && bus.c_eop[gnt_q];
  assign rel = dec && credit_q == wt_width'(1);
`else
  logic unused_eop;
  assign unused_eop = ^bus.c_eop;
  assign dec = xfer;
  assign rel = (dec && credit_q == wt_width'(1)) || !bus.c_srdy[gnt_q];
`endif
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    credit_d = credit_q;
    p_srdy_d = xfer || (p_srdy_q && !bus.p_drdy);
    p_data_d = xfer ? bus.c_data[gnt_q*width +: width] : p_data_q;
    p_grant_d = xfer ? gnt_oh : p_grant_q;
    if (state_q == IDLE) begin
      if (hit) begin
        state_d = GRANT;
        gnt_d = pick;
        credit_d = wt == '0 ? wt_width'(1) : wt;
      end
    end else begin
      if (dec) credit_d = credit_q - 1'b1;
      if (rel) begin
        state_d = IDLE;
        rr_d = gnt_nx;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      credit_q <= '0;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
      p_grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      credit_q <= credit_d;
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
      p_grant_q <= p_grant_d;
    end
  end
  assign bus.c_drdy = ok ? gnt_oh : '0;
  assign bus.p_srdy = p_srdy_q;
  assign bus.p_data = p_data_q;
  assign bus.p_grant = p_grant_q;
endmodule

// File: tb/tb_sd_wrr_sched.sv
// tb_sd_wrr_sched: vector table plus corner-case sequences; beat order checked by a transaction-level scoreboard.
module tb_sd_wrr_sched;
  localparam int N = 4, W = 8, WW = 4;
`ifdef SD_WRR_SCHED_EOP_LOCK_EN
  localparam bit EOP = 1'b1;
`else
  localparam bit EOP = 1'b0;
`endif
  typedef struct packed { logic [N-1:0] g; logic [W-1:0] d; } beat_t;
  typedef struct { int wt[N]; int cnt[N]; logic [N-1:0] first; bit rnd; } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sd_wrr_sched_if #(.inputs(N), .width(W), .wt_width(WW)) bus();
  sd_wrr_sched #(.inputs(N), .width(W), .wt_width(WW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [W-1:0] srcq [N][$];
  logic         eopq [N][$];
  beat_t        exp_q [$];
  logic [N-1:0] fire;
  int           pmode, gap_cnt, gap_at;
  int           compared = 0, mismatched = 0;
  vec_t         tbl [6];
  logic [N-1:0] pat [9];
  logic [N-1:0] first_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      eopq[i].delete();
    end
    exp_q.delete();
    fire = '0;
    gap_cnt = 0;
    gap_at = -1;
    pmode = 0;
    bus.c_srdy = '0;
    bus.c_data = '0;
    bus.c_eop = '0;
    bus.cfg_weight = '0;
    bus.p_drdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_wt(input int wt[N]);
    for (int i = 0; i < N; i++) bus.cfg_weight[i*WW +: WW] = WW'(wt[i]);
  endtask

  task automatic load(input int ch, input int n, input bit last_only);
    for (int k = 0; k < n; k++) begin
      srcq[ch].push_back(W'(ch*16 + k + 1));
      eopq[ch].push_back(last_only ? (k == n - 1) : 1'b1);
    end
  endtask

  task automatic push_exp(input int ch, input int k);
    beat_t e;
    e.g = '0;
    e.g[ch] = 1'b1;
    e.d = W'(ch*16 + k + 1);
    exp_q.push_back(e);
  endtask

  // Transaction-level view: each grant serves min(weight, remaining) beats, then rotates.
  task automatic model(input int wt[N], input int cnt[N]);
    int rem[N];
    int k[N];
    int ptr, g, n;
    ptr = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = cnt[i];
      k[i] = 0;
    end
    forever begin
      g = -1;
      for (int j = N - 1; j >= 0; j--) if (rem[(ptr + j) % N] > 0) g = (ptr + j) % N;
      if (g < 0) break;
      n = wt[g] == 0 ? 1 : wt[g];
      if (n > rem[g]) n = rem[g];
      repeat (n) begin
        push_exp(g, k[g]);
        k[g]++;
        rem[g]--;
      end
      ptr = (g + 1) % N;
    end
  endtask

  task automatic cycle();
    beat_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (fire[i]) begin
        void'(srcq[i].pop_front());
        void'(eopq[i].pop_front());
      end
    if (gap_at >= 0 && srcq[1].size() == gap_at) begin
      gap_cnt = 2;
      gap_at = -1;
    end
    for (int i = 0; i < N; i++) begin
      bus.c_srdy[i] = srcq[i].size() > 0 && !(i == 1 && gap_cnt > 0);
      bus.c_data[i*W +: W] = srcq[i].size() > 0 ? srcq[i][0] : '0;
      bus.c_eop[i] = eopq[i].size() > 0 ? eopq[i][0] : 1'b0;
    end
    if (gap_cnt > 0) gap_cnt--;
    bus.p_drdy = pmode == 0 ? 1'b1 : pmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if (bus.p_srdy && bus.p_drdy) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL extra_beat: got grant %0h data %0h, want no beat", bus.p_grant, bus.p_data);
      end else begin
        e = exp_q.pop_front();
        check("grant", 32'(bus.p_grant), 32'(e.g));
        check("data", 32'(bus.p_data), 32'(e.d));
      end
    end
    fire = bus.c_srdy & bus.c_drdy;
  endtask

  task automatic run(output logic [N-1:0] fg);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    fg = '0;
    while (exp_q.size() > 0 && t < 400) begin
      cycle();
      if (!got && bus.p_srdy && bus.p_drdy) begin
        fg = bus.p_grant;
        got = 1'b1;
      end
      t++;
    end
    check("all_beats_out", 32'(exp_q.size()), 0);
  endtask

  function automatic bit divisible(vec_t v);
    for (int i = 0; i < N; i++) begin
      int w;
      w = v.wt[i] == 0 ? 1 : v.wt[i];
      if (v.cnt[i] % w != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    int w4[N];
    int t;
    logic [W-1:0] held;
    tbl[0] = '{'{1, 1, 1, 1}, '{2, 2, 2, 2}, 4'b0001, 1'b0};
    tbl[1] = '{'{1, 1, 3, 1}, '{0, 0, 6, 0}, 4'b0100, 1'b0};
    tbl[2] = '{'{1, 0, 1, 1}, '{0, 3, 0, 2}, 4'b0010, 1'b0};
    tbl[3] = '{'{2, 3, 1, 4}, '{4, 6, 3, 8}, 4'b0001, 1'b1};
    tbl[4] = '{'{3, 1, 2, 5}, '{5, 2, 1, 3}, 4'b0001, 1'b1};
    tbl[5] = '{'{15, 2, 7, 1}, '{15, 5, 7, 0}, 4'b0001, 1'b0};
    pat = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};

    reset_dut();
    check("rst_p_srdy", 32'(bus.p_srdy), 0);
    check("rst_p_grant", 32'(bus.p_grant), 0);
    check("rst_c_drdy", 32'(bus.c_drdy), 0);

    for (int r = 0; r < 6; r++) begin
      if (EOP && !divisible(tbl[r])) continue;
      reset_dut();
      set_wt(tbl[r].wt);
      for (int i = 0; i < N; i++) load(i, tbl[r].cnt[i], 1'b0);
      model(tbl[r].wt, tbl[r].cnt);
      pmode = tbl[r].rnd ? 1 : 0;
      run(first_g);
      check($sformatf("row%0d_first_grant", r), 32'(first_g), 32'(tbl[r].first));
    end

    // Lone requester: three beats, one arbitration bubble, re-grant.
    reset_dut();
    w4 = '{1, 1, 3, 1};
    set_wt(w4);
    load(2, 6, 1'b0);
    model(w4, '{0, 0, 6, 0});
    for (int j = 0; j < 9; j++) begin
      cycle();
      check($sformatf("bubble_c_drdy%0d", j), 32'(bus.c_drdy), 32'(pat[j]));
    end
    run(first_g);

    // Backpressure: output and data hold while p_drdy is low.
    reset_dut();
    w4 = '{4, 1, 1, 1};
    set_wt(w4);
    load(0, 3, 1'b0);
    model(w4, '{3, 0, 0, 0});
    pmode = 2;
    t = 0;
    while (!bus.p_srdy && t < 10) begin
      cycle();
      t++;
    end
    check("hold_start_p_srdy", 32'(bus.p_srdy), 1);
    held = bus.p_data;
    check("hold_first_data", 32'(held), 32'h01);
    repeat (5) begin
      cycle();
      check("hold_c_drdy", 32'(bus.c_drdy), 0);
      check("hold_p_srdy", 32'(bus.p_srdy), 1);
      check("hold_p_data", 32'(bus.p_data), 32'h01);
    end
    pmode = 0;
    cycle();
    check("resume_c_drdy", 32'(bus.c_drdy), 32'h1);
    run(first_g);

    // Reset in the middle of a grant with p_srdy high clears everything, rr_ptr included.
    reset_dut();
    w4 = '{4, 1, 2, 1};
    set_wt(w4);
    load(2, 2, 1'b0);
    model(w4, '{0, 0, 2, 0});
    run(first_g);
    load(0, 4, 1'b0);
    pmode = 2;
    t = 0;
    while (!bus.p_srdy && t < 10) begin
      cycle();
      t++;
    end
    check("pre_reset_p_srdy", 32'(bus.p_srdy), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_reset_p_srdy", 32'(bus.p_srdy), 0);
    check("mid_reset_p_data", 32'(bus.p_data), 0);
    check("mid_reset_p_grant", 32'(bus.p_grant), 0);
    check("mid_reset_c_drdy", 32'(bus.c_drdy), 0);
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      eopq[i].delete();
    end
    fire = '0;
    @(negedge clk);
    reset = 1'b0;
    pmode = 0;
    w4 = '{1, 1, 1, 1};
    set_wt(w4);
    load(1, 1, 1'b0);
    load(3, 1, 1'b0);
    model(w4, '{0, 1, 0, 1});
    cycle();
    check("post_reset_idle_c_drdy", 32'(bus.c_drdy), 0);
    run(first_g);
    check("post_reset_first_grant", 32'(first_g), 32'h2);

`ifdef SD_WRR_SCHED_EOP_LOCK_EN
    // Packet lock: a c_srdy gap mid-packet keeps the grant on ch1.
    reset_dut();
    w4 = '{1, 1, 1, 1};
    set_wt(w4);
    load(1, 5, 1'b1);
    load(2, 2, 1'b0);
    for (int k = 0; k < 5; k++) push_exp(1, k);
    for (int k = 0; k < 2; k++) push_exp(2, k);
    gap_at = 3;
    run(first_g);
    check("eop_first_grant", 32'(first_g), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
